// File: rtl/i2c_pkg.sv
// Shared types for the I2C byte master: command ops, FSM states,
// frame length and the per-bit SDA pull-low helper.
package i2c_pkg;

    typedef enum logic [1:0] {
        OP_START = 2'd0,
        OP_WRITE = 2'd1,
        OP_READ  = 2'd2,
        OP_STOP  = 2'd3
    } i2c_op_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_START,
        ST_XFER,
        ST_STOP
    } i2c_state_e;

    localparam int I2C_BITS_PER_BYTE = 9;

    // SDA pull-low for bit idx of a transfer (idx 8 is the ACK slot)
    function automatic logic bit_pull(
        input i2c_op_e    op,
        input logic [7:0] data,
        input logic       nack,
        input logic [3:0] idx
    );
        logic [2:0] pos;
        pos = 3'd7 - idx[2:0];
        if (idx == 4'(I2C_BITS_PER_BYTE - 1))
            return (op == OP_READ) && !nack;
        return (op == OP_WRITE) && !data[pos];
    endfunction

endpackage

// File: rtl/i2c_byte_master_phase_gen.sv
// Quarter-bit phase generator: divides clk by CLK_DIV, steps phase 0..3.
// With I2C_CLK_STRETCH_EN defined, phase 1 holds while the bus SCL is low.
module i2c_phase_gen #(
    parameter int CLK_DIV = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       clear,
    input  logic       run,
    input  logic       scl_in,
    output logic [1:0] phase,
    output logic       phase_end
);

    localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

    logic [CW-1:0] cnt;
    logic          hold;

`ifdef I2C_CLK_STRETCH_EN
    assign hold = (phase == 2'd1) && !scl_in;
`else
    logic unused_scl;
    assign unused_scl = scl_in;
    assign hold = 1'b0;
`endif

    assign phase_end = run && !hold && (cnt == LAST);

    // Divider and phase index; restarts at phase 0 on command accept
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt   <= '0;
            phase <= 2'd0;
        end else if (clear) begin
            cnt   <= '0;
            phase <= 2'd0;
        end else if (run && !hold) begin
            if (cnt == LAST) begin
                cnt   <= '0;
                phase <= phase + 2'd1;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/i2c_byte_master.sv
// Byte-level I2C master: START/WRITE/READ/STOP commands to open-drain SCL/SDA.
// Optional slave clock stretching via I2C_CLK_STRETCH_EN.
module i2c_byte_master
    import i2c_pkg::*;
#(
    parameter int CLK_DIV = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [1:0] cmd_op,
    input  logic [7:0] cmd_data,
    input  logic       cmd_nack,
    output logic       rsp_valid,
    output logic [7:0] rsp_data,
    output logic       rsp_nack,
    output logic       busy,
    output logic       scl_oe,
    output logic       sda_oe,
    input  logic       scl_in,
    input  logic       sda_in
);

    localparam logic [3:0] LAST_BIT = 4'(I2C_BITS_PER_BYTE - 1);

    i2c_state_e state;
    i2c_op_e    op;
    i2c_op_e    op_in;
    logic [7:0] data;
    logic       nack;
    logic       bad;
    logic       owned;
    logic [3:0] bit_cnt;
    logic [8:0] sh;
    logic [1:0] phase;
    logic       phase_end;
    logic       accept;

    assign op_in     = i2c_op_e'(cmd_op);
    assign cmd_ready = (state == ST_IDLE);
    assign busy      = !cmd_ready;
    assign accept    = cmd_valid && cmd_ready;

    i2c_phase_gen #(
        .CLK_DIV (CLK_DIV)
    ) u_phase (
        .clk       (clk),
        .rst       (rst),
        .clear     (accept),
        .run       ((state != ST_IDLE) && !bad),
        .scl_in    (scl_in),
        .phase     (phase),
        .phase_end (phase_end)
    );

    // Command FSM; bus enables are set at each phase boundary for the next phase
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_IDLE;
            op        <= OP_START;
            data      <= 8'd0;
            nack      <= 1'b0;
            bad       <= 1'b0;
            owned     <= 1'b0;
            bit_cnt   <= 4'd0;
            sh        <= 9'd0;
            scl_oe    <= 1'b0;
            sda_oe    <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_data  <= 8'd0;
            rsp_nack  <= 1'b0;
        end else begin
            rsp_valid <= 1'b0;
            if (state == ST_IDLE) begin
                if (cmd_valid) begin
                    op      <= op_in;
                    data    <= cmd_data;
                    nack    <= cmd_nack;
                    bit_cnt <= 4'd0;
                    sh      <= 9'd0;
                    bad     <= (op_in != OP_START) && !owned;
                    case (op_in)
                        OP_START: begin
                            state  <= ST_START;
                            sda_oe <= 1'b0;
                        end
                        OP_STOP: begin
                            state <= ST_STOP;
                            if (owned) begin
                                scl_oe <= 1'b1;
                                sda_oe <= 1'b1;
                            end
                        end
                        default: begin
                            state <= ST_XFER;
                            if (owned) begin
                                scl_oe <= 1'b1;
                                sda_oe <= bit_pull(op_in, cmd_data,
                                                   cmd_nack, 4'd0);
                            end
                        end
                    endcase
                end
            end else if (bad) begin
                state     <= ST_IDLE;
                bad       <= 1'b0;
                rsp_valid <= 1'b1;
                rsp_data  <= 8'd0;
                rsp_nack  <= 1'b1;
            end else if (phase_end) begin
                case (state)
                    ST_START: begin
                        case (phase)
                            2'd0: scl_oe <= 1'b0;
                            2'd1: sda_oe <= 1'b1;
                            2'd2: scl_oe <= 1'b1;
                            default: begin
                                state     <= ST_IDLE;
                                owned     <= 1'b1;
                                rsp_valid <= 1'b1;
                                rsp_data  <= 8'd0;
                                rsp_nack  <= 1'b0;
                            end
                        endcase
                    end
                    ST_XFER: begin
                        case (phase)
                            2'd0: scl_oe <= 1'b0;
                            2'd2: begin
                                scl_oe <= 1'b1;
                                sh     <= {sh[7:0], sda_in};
                            end
                            2'd3: begin
                                if (bit_cnt == LAST_BIT) begin
                                    state     <= ST_IDLE;
                                    rsp_valid <= 1'b1;
                                    rsp_data  <= (op == OP_READ) ?
                                                 sh[8:1] : 8'd0;
                                    rsp_nack  <= (op == OP_WRITE) && sh[0];
                                end else begin
                                    bit_cnt <= bit_cnt + 4'd1;
                                    sda_oe  <= bit_pull(op, data, nack,
                                                        bit_cnt + 4'd1);
                                end
                            end
                            default: ;
                        endcase
                    end
                    ST_STOP: begin
                        case (phase)
                            2'd0: scl_oe <= 1'b0;
                            2'd1: sda_oe <= 1'b0;
                            2'd3: begin
                                state     <= ST_IDLE;
                                owned     <= 1'b0;
                                rsp_valid <= 1'b1;
                                rsp_data  <= 8'd0;
                                rsp_nack  <= 1'b0;
                            end
                            default: ;
                        endcase
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_i2c_byte_master.sv
// Self-checking bench for i2c_byte_master (CLK_DIV=2) with a bus-level
// waveform model, a slave model and a START/STOP/bit monitor.
module tb_i2c_byte_master;

    localparam int C = 2;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       cmd_valid = 1'b0;
    logic       cmd_ready;
    logic [1:0] cmd_op = 2'd0;
    logic [7:0] cmd_data = 8'd0;
    logic       cmd_nack = 1'b0;
    logic       rsp_valid;
    logic [7:0] rsp_data;
    logic       rsp_nack;
    logic       busy;
    logic       scl_oe;
    logic       sda_oe;
    logic       scl_in;
    logic       sda_in;

    i2c_byte_master #(
        .CLK_DIV (C)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_data  (cmd_data),
        .cmd_nack  (cmd_nack),
        .rsp_valid (rsp_valid),
        .rsp_data  (rsp_data),
        .rsp_nack  (rsp_nack),
        .busy      (busy),
        .scl_oe    (scl_oe),
        .sda_oe    (sda_oe),
        .scl_in    (scl_in),
        .sda_in    (sda_in)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)",
                     name, act, exp, $time);
        end
    endtask

    // ---------------- slave + bus ----------------
    logic       slave_en = 1'b0;
    logic [8:0] slave_pat = 9'h1FF;
    logic       scl_hold = 1'b0;
    logic       slave_sda_low;
    int         falls = 0;
    int         base = 0;

    always_comb begin
        int k;
        slave_sda_low = 1'b0;
        k = falls - base;
        if (slave_en && k >= 0 && k < 9 && !slave_pat[8 - k])
            slave_sda_low = 1'b1;
    end

    assign scl_in = ~(scl_oe | scl_hold);
    assign sda_in = ~(sda_oe | slave_sda_low);

    // ---------------- bus monitor ----------------
    logic pscl = 1'b1;
    logic psda = 1'b1;
    int   starts = 0;
    int   stops = 0;
    bit   bits_q[$];

    always @(posedge clk) begin
        if (pscl && !scl_in) falls++;
        if (pscl && scl_in && psda && !sda_in) starts++;
        if (pscl && scl_in && !psda && sda_in) stops++;
        if (!pscl && scl_in) bits_q.push_back(sda_in);
        pscl = scl_in;
        psda = sda_in;
    end

    // ---------------- waveform model ----------------
    typedef struct packed {
        logic       scl;
        logic       sda;
        logic       rv;
        logic       rdy;
        logic [7:0] data;
        logic       nack;
    } exp_t;

    exp_t       q[$];
    logic       m_scl = 1'b0;
    logic       m_sda = 1'b0;
    logic       m_owned = 1'b0;
    logic [7:0] m_data = 8'd0;
    logic       m_nack = 1'b0;
    bit         chk_en = 1'b0;

    task automatic model_reset();
        m_scl = 1'b0;
        m_sda = 1'b0;
        m_owned = 1'b0;
        m_data = 8'd0;
        m_nack = 1'b0;
        q.delete();
    endtask

    task automatic push_phase(input logic scl, input logic sda);
        for (int i = 0; i < C; i++)
            q.push_back('{scl, sda, 1'b0, 1'b0, m_data, m_nack});
        m_scl = scl;
        m_sda = sda;
    endtask

    task automatic push_done(input logic [7:0] d, input logic n);
        m_data = d;
        m_nack = n;
        q.push_back('{m_scl, m_sda, 1'b1, 1'b1, d, n});
    endtask

    task automatic model(input logic [1:0] op, input logic [7:0] d,
                         input logic nk, input logic [8:0] pat);
        logic [8:0] smp;
        logic       p;
        smp = 9'd0;
        if (op != 2'd0 && !m_owned) begin
            q.push_back('{m_scl, m_sda, 1'b0, 1'b0, m_data, m_nack});
            push_done(8'd0, 1'b1);
        end else if (op == 2'd0) begin
            push_phase(m_scl, 1'b0);
            push_phase(1'b0, 1'b0);
            push_phase(1'b0, 1'b1);
            push_phase(1'b1, 1'b1);
            m_owned = 1'b1;
            push_done(8'd0, 1'b0);
        end else if (op == 2'd3) begin
            push_phase(1'b1, 1'b1);
            push_phase(1'b0, 1'b1);
            push_phase(1'b0, 1'b0);
            push_phase(1'b0, 1'b0);
            m_owned = 1'b0;
            push_done(8'd0, 1'b0);
        end else begin
            for (int n = 0; n < 9; n++) begin
                if (n < 8) p = (op == 2'd1) ? ~d[7 - n] : 1'b0;
                else       p = (op == 2'd2) ? ~nk : 1'b0;
                smp[8 - n] = ~p & pat[8 - n];
                push_phase(1'b1, p);
                push_phase(1'b0, p);
                push_phase(1'b0, p);
                push_phase(1'b1, p);
            end
            if (op == 2'd1) push_done(8'd0, smp[0]);
            else            push_done(smp[8:1], 1'b0);
        end
    endtask

    // Per-cycle comparison of every output against the model
    always @(negedge clk) begin
        exp_t e;
        if (chk_en) begin
            if (q.size() > 0) e = q.pop_front();
            else e = '{m_scl, m_sda, 1'b0, 1'b1, m_data, m_nack};
            check("outputs",
                  {19'd0, scl_oe, sda_oe, rsp_valid, cmd_ready, busy,
                   rsp_data, rsp_nack},
                  {19'd0, e.scl, e.sda, e.rv, e.rdy, ~e.rdy,
                   e.data, e.nack});
        end
    end

    // ---------------- command driver ----------------
    task automatic do_cmd(input logic [1:0] op, input logic [7:0] d,
                          input logic nk, input logic [8:0] pat,
                          output int lat);
        int t0;
        bit done;
        @(negedge clk);
        slave_pat = pat;
        slave_en  = (op == 2'd1) || (op == 2'd2);
        cmd_op    = op;
        cmd_data  = d;
        cmd_nack  = nk;
        cmd_valid = 1'b1;
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        t0 = cyc;
        base = falls;
        bits_q.delete();
        if (chk_en) model(op, d, nk, pat);
        done = 0;
        lat = -1;
        for (int i = 0; i < 4000 && !done; i++) begin
            @(negedge clk);
            if (rsp_valid) begin
                done = 1;
                lat = cyc - t0;
            end
        end
        if (!done) begin
            n_cmp++;
            n_bad++;
            $display("FAIL timeout: no rsp_valid for op %0d", op);
            q.delete();
        end
        slave_en = 1'b0;
    endtask

    function automatic logic [8:0] bits9();
        logic [8:0] b;
        b = 9'h000;
        for (int i = 0; i < 9; i++)
            if (i < bits_q.size()) b = {b[7:0], bits_q[i]};
        return b;
    endfunction

    int lat;
    int s0;

    initial begin
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        @(negedge clk);
        check("reset_outputs",
              {19'd0, scl_oe, sda_oe, rsp_valid, cmd_ready, busy,
               rsp_data, rsp_nack},
              32'h0000_0400);
        chk_en = 1'b1;

        s0 = starts;
        do_cmd(2'd0, 8'h00, 1'b0, 9'h1FF, lat);
        check("start_latency", lat, 8);
        check("start_condition", starts - s0, 1);

        do_cmd(2'd1, 8'hA5, 1'b0, {8'hFF, 1'b0}, lat);
        check("write_latency", lat, 72);
        check("write_bits", bits_q.size(), 9);
        check("write_sda_pattern", bits9(), {8'hA5, 1'b0});
        check("write_ack_nack", rsp_nack, 1'b0);

        do_cmd(2'd1, 8'h5A, 1'b0, 9'h1FF, lat);
        check("write_noslave_nack", rsp_nack, 1'b1);

        do_cmd(2'd2, 8'h00, 1'b1, {8'h3C, 1'b1}, lat);
        check("read_latency", lat, 72);
        check("read_data", rsp_data, 8'h3C);
        check("read_ackslot_released", bits9(), {8'h3C, 1'b1});

        s0 = stops;
        do_cmd(2'd3, 8'h00, 1'b0, 9'h1FF, lat);
        check("stop_latency", lat, 8);
        check("stop_condition", stops - s0, 1);
        check("stop_released", {scl_oe, sda_oe}, 2'b00);
        check("stop_rsp_data", rsp_data, 8'h00);

        s0 = falls;
        do_cmd(2'd1, 8'hFF, 1'b0, 9'h1FF, lat);
        check("illegal_latency", lat, 1);
        check("illegal_nack", rsp_nack, 1'b1);
        check("illegal_no_bus", {scl_oe, sda_oe}, 2'b00);
        check("illegal_no_scl_edges", falls - s0, 0);

        do_cmd(2'd0, 8'h00, 1'b0, 9'h1FF, lat);
        chk_en = 1'b0;
        q.delete();
        @(negedge clk);
        cmd_op = 2'd1;
        cmd_data = 8'h00;
        cmd_valid = 1'b1;
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        repeat (20) @(posedge clk);
        #1;
        check("midwrite_busy", busy, 1'b1);
        #2;
        rst = 1'b1;
        #1;
        check("midreset_released", {scl_oe, sda_oe}, 2'b00);
        check("midreset_ready", cmd_ready, 1'b1);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        model_reset();
        chk_en = 1'b1;
        @(negedge clk);

`ifdef I2C_CLK_STRETCH_EN
        do_cmd(2'd0, 8'h00, 1'b0, 9'h1FF, lat);
        chk_en = 1'b0;
        fork
            do_cmd(2'd1, 8'hA5, 1'b0, {8'hFF, 1'b0}, lat);
            begin
                bit hit;
                hit = 0;
                for (int i = 0; i < 2000 && !hit; i++) begin
                    @(negedge clk);
                    if (falls - base == 3 && !scl_oe) hit = 1;
                end
                if (hit) begin
                    scl_hold = 1'b1;
                    repeat (10) @(posedge clk);
                    @(negedge clk);
                    scl_hold = 1'b0;
                end else begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL stretch_trigger: bit 3 never reached");
                end
            end
        join
        check("stretch_latency", lat, 82);
        check("stretch_sda_pattern", bits9(), {8'hA5, 1'b0});
        check("stretch_nack", rsp_nack, 1'b0);
`endif

        chk_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
